// File: rtl/add8u_err_profiler.sv
// add8u_err_profiler
//   Exhaustive error-characterisation engine for one approximate unsigned
//   adder. A sweep presents every (a,b) operand pair once, one pair per
//   cycle. Each DUT sum is compared with the exact sum, and the engine
//   accumulates the total absolute error, the total squared error, the
//   count of erroneous pairs and the worst-case error. It also records the
//   first pair that reached the worst-case error.
//
//   State table:
//     IDLE  | waiting for start; results of the last sweep are held
//     RUN   | presenting one operand pair per cycle
//     DRAIN | LAT cycles flushing the operand delay line; dut_a/dut_b hold
//
// Parameters:
//   W   - operand width of the adder under test
//   LAT - DUT latency in cycles (0..3); 0 means a combinational adder
//
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   start          - begin a sweep (sampled only in IDLE)
//   busy, done     - sweep in progress / one-cycle completion pulse
//   dut_a, dut_b   - registered operands driven to the adder under test
//   dut_o          - sum returned by the adder under test
//   err_sum        - sum of |exact - dut_o|
//   err_sq_sum     - sum of (exact - dut_o)^2
//   err_cnt        - number of pairs with a nonzero error
//   wce            - largest |error| seen
//   wce_a, wce_b   - first pair (in sweep order) that reached wce
module add8u_err_profiler #(
  parameter int W   = 8,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   dut_a,
  output logic [W-1:0]   dut_b,
  input  logic [W:0]     dut_o,
  output logic [3*W:0]   err_sum,
  output logic [4*W+1:0] err_sq_sum,
  output logic [2*W:0]   err_cnt,
  output logic [W:0]     wce,
  output logic [W-1:0]   wce_a,
  output logic [W-1:0]   wce_b
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The drain down-counter starts at LAT-1 and leaves DRAIN at zero.
  localparam logic [1:0] DRAIN_LOAD = 2'((LAT > 0) ? LAT - 1 : 0);

  state_t state_q, state_d;
  logic [1:0]   drain_q, drain_d;
  logic [2*W-1:0] pair_q, pair_d;  // {a, b}: b is the fast-moving half
  logic         done_q, done_d;
  logic         start_acc;

  logic [3*W:0]   err_sum_q, err_sum_d;
  logic [4*W+1:0] err_sq_q, err_sq_d;
  logic [2*W:0]   err_cnt_q, err_cnt_d;
  logic [W:0]     wce_q, wce_d;
  logic [W-1:0]   wce_a_q, wce_a_d;
  logic [W-1:0]   wce_b_q, wce_b_d;

  // Operands and valid flag aligned with the DUT result currently on dut_o.
  logic [W-1:0] tap_a, tap_b;
  logic         tap_v;

  assign dut_a = pair_q[2*W-1:W];
  assign dut_b = pair_q[W-1:0];

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    pair_d    = pair_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          pair_d    = '0;
          start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (&pair_q) begin
          // Last pair: hold it on the operand outputs.
          if (LAT == 0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else begin
          pair_d = pair_q + (2*W)'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= 2'd0;
      pair_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pair_q  <= pair_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // Operand delay line: a pair presented in cycle t reaches the tap in
  // cycle t+LAT, the same cycle the DUT returns its sum.
  if (LAT == 0) begin : g_no_delay
    assign tap_a = dut_a;
    assign tap_b = dut_b;
    assign tap_v = (state_q == ST_RUN);
  end else begin : g_delay
    logic [LAT-1:0][W-1:0] dl_a_q, dl_a_d;
    logic [LAT-1:0][W-1:0] dl_b_q, dl_b_d;
    logic [LAT-1:0]        dl_v_q, dl_v_d;

    always_comb begin
      dl_a_d    = dl_a_q;
      dl_b_d    = dl_b_q;
      dl_v_d    = dl_v_q;
      dl_a_d[0] = dut_a;
      dl_b_d[0] = dut_b;
      dl_v_d[0] = (state_q == ST_RUN);
      for (int i = 1; i < LAT; i++) begin
        dl_a_d[i] = dl_a_q[i-1];
        dl_b_d[i] = dl_b_q[i-1];
        dl_v_d[i] = dl_v_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dl_a_q <= '0;
        dl_b_q <= '0;
        dl_v_q <= '0;
      end else begin
        dl_a_q <= dl_a_d;
        dl_b_q <= dl_b_d;
        dl_v_q <= dl_v_d;
      end
    end

    assign tap_a = dl_a_q[LAT-1];
    assign tap_b = dl_b_q[LAT-1];
    assign tap_v = dl_v_q[LAT-1];
  end

  logic [W:0]     exact;
  logic [W:0]     err_abs;
  logic [2*W+1:0] err_sq;

  always_comb begin
    exact = {1'b0, tap_a} + {1'b0, tap_b};
    // |exact - dut_o| computed unsigned, avoiding a signed intermediate.
    if (exact >= dut_o) err_abs = exact - dut_o;
    else                err_abs = dut_o - exact;
    err_sq = (2*W+2)'(err_abs) * (2*W+2)'(err_abs);

    err_sum_d = err_sum_q;
    err_sq_d  = err_sq_q;
    err_cnt_d = err_cnt_q;
    wce_d     = wce_q;
    wce_a_d   = wce_a_q;
    wce_b_d   = wce_b_q;
    if (start_acc) begin
      err_sum_d = '0;
      err_sq_d  = '0;
      err_cnt_d = '0;
      wce_d     = '0;
      wce_a_d   = '0;
      wce_b_d   = '0;
    end else if (tap_v) begin
      err_sum_d = err_sum_q + (3*W+1)'(err_abs);
      err_sq_d  = err_sq_q + (4*W+2)'(err_sq);
      if (err_abs != '0) err_cnt_d = err_cnt_q + (2*W+1)'(1);
      // Strictly greater only, so the first worst pair in sweep order wins.
      if (err_abs > wce_q) begin
        wce_d   = err_abs;
        wce_a_d = tap_a;
        wce_b_d = tap_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_q <= '0;
      err_sq_q  <= '0;
      err_cnt_q <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      err_sq_q  <= err_sq_d;
      err_cnt_q <= err_cnt_d;
      wce_q     <= wce_d;
      wce_a_q   <= wce_a_d;
      wce_b_q   <= wce_b_d;
    end
  end

  assign err_sum    = err_sum_q;
  assign err_sq_sum = err_sq_q;
  assign err_cnt    = err_cnt_q;
  assign wce        = wce_q;
  assign wce_a      = wce_a_q;
  assign wce_b      = wce_b_q;

endmodule
